// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: word-addressed RAM behind a
// request/done four-phase handshake with a programmable number of wait states.
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  busy,
    output logic                  err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [CW-1:0]           cnt_r;
    logic [CW-1:0]           cnt_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic                    is_write_r;
    logic                    accept_s;
    logic                    req_active_s;
    logic                    err_s;
    logic                    ram_we_s;
    logic [DATA_WIDTH-1:0]   data_out_r;
    logic                    done_r;
    logic [DATA_WIDTH-1:0]   ram_r [DEPTH];

    // Next-state, wait counter and request acceptance decode
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        accept_s     = 1'b0;
        err_s        = 1'b0;
        req_active_s = is_write_r ? mem_write : mem_read;
        case (state_r)
            ST_IDLE: begin
                if (mem_read && mem_write) begin
                    err_s = 1'b1;
                end else if (mem_read || mem_write) begin
                    accept_s = 1'b1;
                    cnt_s    = CW'(WAIT_STATES);
                    state_s  = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A dropped request wins over reaching the end of the wait
                if (!req_active_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CW{1'b0}};
                end else if (cnt_r == CW'(1)) begin
                    state_s = ST_ACCESS;
                    cnt_s   = cnt_r - CW'(1);
                end else begin
                    cnt_s   = cnt_r - CW'(1);
                end
            end
            ST_ACCESS: begin
                state_s = ST_DONE;
            end
            ST_DONE: begin
                if (!req_active_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    assign ram_we_s = (state_r == ST_ACCESS) && is_write_r;
    assign err      = err_s;
    assign busy     = (state_r != ST_IDLE);
    assign data_out = data_out_r;
    assign done     = done_r;

    // State, counter and done register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Request latch at acceptance and read data capture at the ACCESS edge
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            addr_r     <= {ADDR_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            is_write_r <= 1'b0;
            data_out_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (accept_s) begin
                addr_r     <= address;
                wdata_r    <= data_in;
                is_write_r <= mem_write;
            end
            if ((state_r == ST_ACCESS) && !is_write_r) begin
                data_out_r <= ram_r[addr_r];
            end
        end
    end

    // RAM write port; contents survive reset, state reset blocks pending writes
    always_ff @(posedge clock) begin
        if (ram_we_s) begin
            ram_r[addr_r] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with two wait states and
// one with zero wait states; a monitor checks data_out at each rising done.
module tb_mem_responder;

    logic        clock;
    logic        clear;
    logic [8:0]  address;
    logic [31:0] data_in;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] dout0;
    logic [31:0] dout1;
    logic [1:0]  done_v;
    logic [1:0]  busy_v;
    logic [1:0]  err_v;
    logic [1:0]  prev_done;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          total;
    int          bad;

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(2)) dut0 (
        .clock(clock), .clear(clear), .mem_read(rd[0]), .mem_write(wr[0]),
        .address(address), .data_in(data_in), .data_out(dout0),
        .done(done_v[0]), .busy(busy_v[0]), .err(err_v[0])
    );

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) dut1 (
        .clock(clock), .clear(clear), .mem_read(rd[1]), .mem_write(wr[1]),
        .address(address), .data_in(data_in), .data_out(dout1),
        .done(done_v[1]), .busy(busy_v[1]), .err(err_v[1])
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every rising done pops the expected data_out for that instance
    always @(negedge clock) begin
        if (done_v[0] && !prev_done[0]) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done0: got 1 want 0");
            end else begin
                chk("dout0", dout0, q0.pop_front());
            end
        end
        if (done_v[1] && !prev_done[1]) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done1: got 1 want 0");
            end else begin
                chk("dout1", dout1, q1.pop_front());
            end
        end
        prev_done = done_v;
    end

    // Full handshake: request, latency check, hold, release, done/busy fall
    task automatic access(input int k, input bit w, input logic [8:0] a,
                          input logic [31:0] d, input logic [31:0] exp,
                          input int hold, input bit scramble);
        int n;
        int ws;
        ws = (k == 0) ? 2 : 0;
        address = a;
        data_in = d;
        if (k == 0) q0.push_back(exp); else q1.push_back(exp);
        if (w) wr[k] = 1'b1; else rd[k] = 1'b1;
        n = 0;
        do begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (scramble && n == 1) begin
                address = ~a;
                data_in = ~d;
            end
        end while (!done_v[k] && n < 20);
        chk("latency", 32'(n - 1), 32'(ws + 1));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("done_hold", 32'(done_v[k]), 32'd1);
        end
        rd[k] = 1'b0;
        wr[k] = 1'b0;
        @(posedge clock);
        #1;
        chk("done_fall", 32'(done_v[k]), 32'd0);
        chk("busy_idle", 32'(busy_v[k]), 32'd0);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        clock = 1'b0; clear = 1'b0; rd = 2'b00; wr = 2'b00;
        address = 9'd0; data_in = 32'd0; prev_done = 2'b00;
        #12;
        chk("rst_dout0", dout0, 32'd0);
        chk("rst_done", 32'(done_v), 32'd0);
        chk("rst_busy", 32'(busy_v), 32'd0);
        chk("rst_err", 32'(err_v), 32'd0);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);

        // Write then read, read held five cycles after done
        access(0, 1'b1, 9'h005, 32'hDEADBEEF, 32'h00000000, 0, 1'b0);
        access(0, 1'b0, 9'h005, 32'h00000000, 32'hDEADBEEF, 5, 1'b0);

        // Conflict: both requests in IDLE
        access(0, 1'b1, 9'h010, 32'h11111111, 32'hDEADBEEF, 0, 1'b0);
        address = 9'h010; data_in = 32'h12345678; rd[0] = 1'b1; wr[0] = 1'b1;
        #1;
        chk("conflict_err", 32'(err_v[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("conflict_err", 32'(err_v[0]), 32'd1);
            chk("conflict_busy", 32'(busy_v[0]), 32'd0);
            chk("conflict_done", 32'(done_v[0]), 32'd0);
        end
        rd[0] = 1'b0; wr[0] = 1'b0;
        #1;
        chk("err_clear", 32'(err_v[0]), 32'd0);
        @(negedge clock);
        access(0, 1'b0, 9'h010, 32'h00000000, 32'h11111111, 0, 1'b0);

        // Abort: write dropped in the first WAIT cycle
        access(0, 1'b1, 9'h1FF, 32'h22222222, 32'h11111111, 0, 1'b0);
        address = 9'h1FF; data_in = 32'hCAFEF00D; wr[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("abort_busy", 32'(busy_v[0]), 32'd1);
        wr[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("abort_idle", 32'(busy_v[0]), 32'd0);
            chk("abort_done", 32'(done_v[0]), 32'd0);
        end
        access(0, 1'b0, 9'h1FF, 32'h00000000, 32'h22222222, 0, 1'b0);

        // Reset asserted between edges while the write sits in ACCESS
        access(0, 1'b1, 9'h020, 32'h33333333, 32'h22222222, 0, 1'b0);
        address = 9'h020; data_in = 32'h0000FFFF; wr[0] = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("access_busy", 32'(busy_v[0]), 32'd1);
        chk("access_done", 32'(done_v[0]), 32'd0);
        clear = 1'b0;
        #1;
        chk("midrst_dout", dout0, 32'd0);
        chk("midrst_done", 32'(done_v[0]), 32'd0);
        chk("midrst_busy", 32'(busy_v[0]), 32'd0);
        @(posedge clock);
        @(negedge clock);
        wr[0] = 1'b0;
        clear = 1'b1;
        @(negedge clock);
        access(0, 1'b0, 9'h020, 32'h00000000, 32'h33333333, 0, 1'b0);

        // Address/data changes after acceptance are ignored
        access(0, 1'b1, 9'h030, 32'h44444444, 32'h33333333, 0, 1'b1);
        access(0, 1'b0, 9'h030, 32'h00000000, 32'h44444444, 0, 1'b1);

        // Zero wait states at both ends of the address range
        access(1, 1'b1, 9'h000, 32'hA5A5A5A5, 32'h00000000, 0, 1'b0);
        access(1, 1'b1, 9'h1FF, 32'h5A5A5A5A, 32'h00000000, 0, 1'b0);
        access(1, 1'b0, 9'h000, 32'h00000000, 32'hA5A5A5A5, 0, 1'b0);
        access(1, 1'b0, 9'h1FF, 32'h00000000, 32'h5A5A5A5A, 2, 1'b0);

        repeat (3) @(negedge clock);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's MAR/MDR memory interface.
- The control unit raises a read or write request with the address taken from MAR and, for writes, the data taken from MDR.
- The responder performs the access on an internal word-addressed RAM after a programmable number of wait states, returns read data on the MDatain path, and signals completion with a four-phase done handshake.

Parameters:
- ADDR_WIDTH, 9, word address width; RAM depth = 2**ADDR_WIDTH words (512).
- DATA_WIDTH, 32, word width; matches the datapath bus.
- WAIT_STATES, 2, cycles spent in WAIT before the access; 0 is legal.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- clear  input  1  reset, asynchronous, active-low; assertion (0) immediately forces reset state.
- mem_read  input  1  read request, level, from control unit; held until done seen.
- mem_write  input  1  write request, level, from control unit; held until done seen.
- address  input  ADDR_WIDTH  word address, driven from MAR; sampled at request acceptance.
- data_in  input  DATA_WIDTH  write data, driven from MDR; sampled at request acceptance.
- data_out  output  DATA_WIDTH  read data to datapath MDatain; holds last completed read.
- done  output  1  access complete; stays high until the request drops.
- busy  output  1  high in WAIT, ACCESS and DONE.
- err  output  1  high while mem_read and mem_write are both high in IDLE.

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE, wait counter=0, data_out=0, done=0, busy=0, err=0.
  - RAM contents are not cleared.
  - Reset mid-operation abandons the access; a pending write is not committed.
- States: IDLE, WAIT, ACCESS, DONE. Encoding is free.
- IDLE:
  - Exactly one of mem_read/mem_write high at a clock edge: accept the request. Latch address, data_in and the direction. Load the counter with WAIT_STATES. Go to WAIT, or to ACCESS if WAIT_STATES=0.
  - Both high: err=1 (combinational from IDLE and both requests); remain in IDLE; no access.
  - Neither high: remain in IDLE.
- WAIT:
  - Counter decrements each edge; go to ACCESS at the edge where counter==1.
  - The request that caused acceptance dropping (sampled 0) at any WAIT edge aborts the access: return to IDLE, no RAM write, data_out unchanged, done never asserted.
- ACCESS (one cycle), at its closing edge:
  - Write: ram[latched_addr] <= latched_data.
  - Read: data_out <= ram[latched_addr].
  - Go to DONE.
  - Requests are not re-examined here; the access always completes.
- DONE:
  - done=1.
  - Stay until the active request is sampled low, then go to IDLE. done falls on that edge.
  - A new request needs a return to IDLE, so back-to-back accesses cost at least one IDLE cycle.
- Latency:
  - Request first sampled at edge 0 gives done high from edge WAIT_STATES+1.
  - WAIT_STATES=2 gives done after edge 3.
  - WAIT_STATES=0 gives done after edge 1.
- Latched values:
  - address and data_in changes after acceptance are ignored.
  - data_out changes only at the ACCESS edge of a read, or on reset.
- Address: full ADDR_WIDTH range is valid (0..2**ADDR_WIDTH-1), with no wrap or alias logic.
- Read-after-write to the same address returns the new data.
- busy = (state != IDLE). All outputs are registered except err and busy, which decode state.

Test Plan:
- Write/read: write 0xDEADBEEF to address 0x005 (WAIT_STATES=2), then read 0x005 -> done rises after edge 3 each time; data_out=0xDEADBEEF after the read's ACCESS edge; data_out unchanged by the write.
- Handshake: hold mem_read for 5 cycles after done -> done stays 1 for those 5 cycles; done falls on the edge where mem_read is sampled 0; next request accepted only from IDLE.
- Conflict: mem_read=mem_write=1 with address=0x010, data_in=0x12345678 -> err=1, busy=0, done never 1; subsequent read of 0x010 returns the prior contents.
- Abort: write 0xCAFEF00D to 0x1FF, drop mem_write in the first WAIT cycle -> return to IDLE; no done; read 0x1FF returns the old value.
- Reset mid-op: assert clear=0 during ACCESS of a write of 0x0000FFFF to 0x020 between edges -> immediate state=IDLE, data_out=0, done=0; read 0x020 returns the old value.
- Boundary/zero-wait: WAIT_STATES=0; write then read 0x000 and 0x1FF with 0xA5A5A5A5 / 0x5A5A5A5A -> done after edge 1; correct distinct data at both ends of the range.
